// File: rtl/mul_div_ctrl.sv
// mul_div_ctrl: RV32M execute-stage sequencer in front of the iterative mul_div unit.
// Latency: accept to writeback beat is 34 cycles through the unit, 3 with a zero operand, 1 for divide-by-zero.
// Backpressure: stall_o holds EX while an op is accepted and for the whole BUSY phase; flush_i kills BUSY.
// Optional feature: define MUL_DIV_CACHE_EN for a one-entry result cache keyed on op class, signedness and operands.
// Ports: clk_i/rst_ni (sync, active-low); ex_* instruction in; flush_i kill; stall_o pipeline hold;
//        md_* request/operands out to the unit and high/low/ready back; wb_* one-cycle writeback beat.
module mul_div_ctrl (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ex_valid_i,
    input  logic [2:0]  ex_funct3_i,
    input  logic [31:0] ex_rs1_i,
    input  logic [31:0] ex_rs2_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        md_req_o,
    output logic [6:0]  md_op_o,
    output logic [2:0]  md_m_d_op_o,
    output logic [31:0] md_rs1_o,
    output logic [31:0] md_rs2_o,
    output logic        md_rs1_signed_o,
    output logic        md_rs2_signed_o,
    input  logic [31:0] md_high_i,
    input  logic [31:0] md_low_i,
    input  logic        md_ready_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o
);
    localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;

    typedef enum logic [1:0] {IDLE, BUSY, WB} state_t;
    state_t state, state_nxt;

    function automatic logic rs1_sgn(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b110);
    endfunction

    function automatic logic rs2_sgn(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b110);
    endfunction

    // Select high/low per funct3. The unit hands back the remainder magnitude,
    // so a signed REM with a negative dividend gets its sign restored here.
    function automatic logic [31:0] md_result(input logic [2:0]  f3,
                                              input logic [31:0] rs1,
                                              input logic [31:0] high,
                                              input logic [31:0] low);
        logic [31:0] sel;
        sel = (f3[2] ? f3[1] : (f3 != 3'b000)) ? high : low;
        if ((f3 == 3'b110) && rs1[31])
            sel = ~sel + 32'd1;
        return sel;
    endfunction

    logic        accept;
    logic        fast;
    logic        hit;
    logic        done;
    logic [4:0]  rd_q;
    logic [31:0] hit_data;

    assign accept = ((state == IDLE) || (state == WB)) && ex_valid_i && !flush_i;
    // Divide by zero has a fixed architectural answer; the unit is never started.
    assign fast   = ex_funct3_i[2] && (ex_rs2_i == 32'd0);
    // Flush wins over a same-cycle completion.
    assign done   = (state == BUSY) && md_ready_i && !flush_i;

`ifdef MUL_DIV_CACHE_EN
    logic        c_vld;
    logic        c_div;
    logic        c_s1;
    logic        c_s2;
    logic [31:0] c_rs1;
    logic [31:0] c_rs2;
    logic [31:0] c_high;
    logic [31:0] c_low;

    // Key covers mul/div class and signedness, so MULH then MUL on the same
    // operands (or DIV then REM) reuses a single unit run.
    assign hit = c_vld && (c_div == ex_funct3_i[2]) &&
                 (c_s1 == rs1_sgn(ex_funct3_i)) && (c_s2 == rs2_sgn(ex_funct3_i)) &&
                 (c_rs1 == ex_rs1_i) && (c_rs2 == ex_rs2_i);
    assign hit_data = md_result(ex_funct3_i, ex_rs1_i, c_high, c_low);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            c_vld  <= 1'b0;
            c_div  <= 1'b0;
            c_s1   <= 1'b0;
            c_s2   <= 1'b0;
            c_rs1  <= '0;
            c_rs2  <= '0;
            c_high <= '0;
            c_low  <= '0;
        end else if (done) begin
            c_vld  <= 1'b1;
            c_div  <= md_m_d_op_o[2];
            c_s1   <= md_rs1_signed_o;
            c_s2   <= md_rs2_signed_o;
            c_rs1  <= md_rs1_o;
            c_rs2  <= md_rs2_o;
            c_high <= md_high_i;
            c_low  <= md_low_i;
        end else if ((state == BUSY) && flush_i) begin
            c_vld  <= 1'b0;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        md_req_o  = 1'b0;
        md_op_o   = '0;
        stall_o   = accept;
        case (state)
            IDLE, WB: begin
                if (accept)
                    state_nxt = (fast || hit) ? WB : BUSY;
                else
                    state_nxt = IDLE;
            end
            BUSY: begin
                md_req_o = 1'b1;
                md_op_o  = INST_TYPE_R_M;
                stall_o  = 1'b1;
                if (flush_i)
                    state_nxt = IDLE;
                else if (md_ready_i)
                    state_nxt = WB;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            md_m_d_op_o     <= '0;
            md_rs1_o        <= '0;
            md_rs2_o        <= '0;
            md_rs1_signed_o <= 1'b0;
            md_rs2_signed_o <= 1'b0;
            rd_q            <= '0;
            wb_valid_o      <= 1'b0;
            wb_rd_o         <= '0;
            wb_data_o       <= '0;
        end else begin
            wb_valid_o <= 1'b0;
            if (accept) begin
                md_m_d_op_o     <= ex_funct3_i;
                md_rs1_o        <= ex_rs1_i;
                md_rs2_o        <= ex_rs2_i;
                md_rs1_signed_o <= rs1_sgn(ex_funct3_i);
                md_rs2_signed_o <= rs2_sgn(ex_funct3_i);
                rd_q            <= ex_rd_i;
                if (fast) begin
                    // DIV/DIVU -> all ones, REM/REMU -> dividend
                    wb_valid_o <= 1'b1;
                    wb_rd_o    <= ex_rd_i;
                    wb_data_o  <= ex_funct3_i[1] ? ex_rs1_i : 32'hFFFF_FFFF;
                end else if (hit) begin
                    wb_valid_o <= 1'b1;
                    wb_rd_o    <= ex_rd_i;
                    wb_data_o  <= hit_data;
                end
            end
            if (done) begin
                wb_valid_o <= 1'b1;
                wb_rd_o    <= rd_q;
                wb_data_o  <= md_result(md_m_d_op_o, md_rs1_o, md_high_i, md_low_i);
            end
        end
    end
endmodule

// File: tb/tb_mul_div_ctrl.sv
module tb_mul_div_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        ex_valid_i = 1'b0;
    logic [2:0]  ex_funct3_i = '0;
    logic [31:0] ex_rs1_i = '0;
    logic [31:0] ex_rs2_i = '0;
    logic [4:0]  ex_rd_i = '0;
    logic        flush_i = 1'b0;
    logic        stall_o;
    logic        md_req_o;
    logic [6:0]  md_op_o;
    logic [2:0]  md_m_d_op_o;
    logic [31:0] md_rs1_o;
    logic [31:0] md_rs2_o;
    logic        md_rs1_signed_o;
    logic        md_rs2_signed_o;
    logic [31:0] md_high_i = '0;
    logic [31:0] md_low_i = '0;
    logic        md_ready_i = 1'b0;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;

    always #5 clk_i = ~clk_i;

    mul_div_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ex_valid_i(ex_valid_i), .ex_funct3_i(ex_funct3_i),
        .ex_rs1_i(ex_rs1_i), .ex_rs2_i(ex_rs2_i), .ex_rd_i(ex_rd_i),
        .flush_i(flush_i), .stall_o(stall_o),
        .md_req_o(md_req_o), .md_op_o(md_op_o), .md_m_d_op_o(md_m_d_op_o),
        .md_rs1_o(md_rs1_o), .md_rs2_o(md_rs2_o),
        .md_rs1_signed_o(md_rs1_signed_o), .md_rs2_signed_o(md_rs2_signed_o),
        .md_high_i(md_high_i), .md_low_i(md_low_i), .md_ready_i(md_ready_i),
        .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          at;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    int          req_lo = 1;
    int          req_hi = 0;
    logic [2:0]  cur_f3 = '0;
    logic [31:0] cur_a = '0;
    logic [31:0] cur_b = '0;
    logic [7:0]  s1_tab = 8'h57;   // funct3 0,1,2,4,6 treat rs1 as signed
    logic [7:0]  s2_tab = 8'h53;   // funct3 0,1,4,6 treat rs2 as signed
    int          ucnt = 0;

    bit          m_vld = 1'b0;
    bit          m_div;
    bit          m_s1;
    bit          m_s2;
    logic [31:0] m_a;
    logic [31:0] m_b;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Architectural RV32M result from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb_, ua, ub, p;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        case (f3)
            3'd0: begin p = sa * sb_; return p[31:0]; end
            3'd1: begin p = sa * sb_; return p[63:32]; end
            3'd2: begin p = sa * ub;  return p[63:32]; end
            3'd3: begin p = ua * ub;  return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb_; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb_; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Stand-in for the iterative unit: {high, low}; signed remainders come back as magnitudes.
    function automatic logic [63:0] unit_calc(input logic [2:0] op, input logic s1, input logic s2,
                                              input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        if (!op[2]) begin
            x = s1 ? longint'($signed(a)) : longint'({32'd0, a});
            y = s2 ? longint'($signed(b)) : longint'({32'd0, b});
            q = x * y;
            return q;
        end
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (!s1) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        x = longint'($signed(a));
        y = longint'($signed(b));
        q = x / y;
        r = (x < 0 ? -x : x) % (y < 0 ? -y : y);
        return {r[31:0], q[31:0]};
    endfunction

    // Unit responder: ready after 32 request edges, or after 1 when an operand is zero.
    always @(posedge clk_i) begin
        if (!md_req_o) begin
            ucnt       <= 0;
            md_ready_i <= 1'b0;
        end else begin
            ucnt       <= ucnt + 1;
            md_ready_i <= ((ucnt + 1) == ((md_rs1_o == 0 || md_rs2_o == 0) ? 1 : 32));
            {md_high_i, md_low_i} <= unit_calc(md_m_d_op_o, md_rs1_signed_o, md_rs2_signed_o,
                                               md_rs1_o, md_rs2_o);
        end
    end

    // Called at a falling edge. abort_after>0 kills the op that many cycles after
    // acceptance, with flush_i or (abort_rst) with a reset pulse.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int abort_after, input bit abort_rst);
        int guard = 0;
        int d, lat;
        bit is_fast, is_hit;
        while (md_req_o) begin
            @(negedge clk_i);
            guard++;
            if (guard > 100) begin
                n_chk++; n_fail++;
                $display("FAIL issue_wait: md_req_o still 1 after %0d cycles, required 0", guard);
                break;
            end
        end
        is_fast = f3[2] && (b == 0);
        is_hit  = 1'b0;
`ifdef MUL_DIV_CACHE_EN
        is_hit = !is_fast && m_vld && (m_div == f3[2]) && (m_s1 == s1_tab[f3]) &&
                 (m_s2 == s2_tab[f3]) && (m_a == a) && (m_b == b);
`endif
        lat = (is_fast || is_hit) ? 1 : ((a == 0 || b == 0) ? 3 : 34);
        d = cyc;
        ex_valid_i = 1'b1; ex_funct3_i = f3; ex_rs1_i = a; ex_rs2_i = b; ex_rd_i = rd;
        cur_f3 = f3; cur_a = a; cur_b = b;
        if (lat > 1) begin
            req_lo = d + 1; req_hi = d + lat - 1;
            if (abort_after > 0) m_vld = 1'b0;
            else begin
                m_vld = 1'b1; m_div = f3[2]; m_s1 = s1_tab[f3]; m_s2 = s2_tab[f3]; m_a = a; m_b = b;
            end
        end else begin
            req_lo = 1; req_hi = 0;
        end
        if (abort_after == 0) sb.push_back('{rd, ref_result(f3, a, b), d + lat});
        @(negedge clk_i);
        ex_valid_i = 1'b0;
        if (abort_after > 0) begin
            repeat (abort_after - 1) @(negedge clk_i);
            req_hi = cyc;
            if (abort_rst) rst_ni = 1'b0; else flush_i = 1'b1;
            @(negedge clk_i);
            rst_ni = 1'b1; flush_i = 1'b0;
            if (abort_rst) m_vld = 1'b0;
        end
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    initial begin : monitor
        exp_t e;
        bit   in_rng;
        wait (mon_en);
        forever begin
            @(negedge clk_i);
            #2;
            in_rng = (cyc >= req_lo) && (cyc <= req_hi);
            chk("md_req", 32'(md_req_o), 32'(in_rng));
            chk("stall", 32'(stall_o), 32'((ex_valid_i && !flush_i) || in_rng));
            chk("md_op", 32'(md_op_o), in_rng ? 32'h33 : 32'h0);
            if (in_rng) begin
                chk("md_m_d_op", 32'(md_m_d_op_o), 32'(cur_f3));
                chk("md_rs1", md_rs1_o, cur_a);
                chk("md_rs2", md_rs2_o, cur_b);
                chk("md_rs1_signed", 32'(md_rs1_signed_o), 32'(s1_tab[cur_f3]));
                chk("md_rs2_signed", 32'(md_rs2_signed_o), 32'(s2_tab[cur_f3]));
            end
            if (wb_valid_o) begin
                if (sb.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL wb_unexpected: beat rd=%0d data=%h with nothing outstanding", wb_rd_o, wb_data_o);
                end else begin
                    e = sb.pop_front();
                    chk("wb_data", wb_data_o, e.data);
                    chk("wb_rd", 32'(wb_rd_o), 32'(e.rd));
                    chk("wb_cycle", cyc, e.at);
                end
            end else if (sb.size() > 0 && cyc > sb[0].at) begin
                e = sb.pop_front();
                n_chk++; n_fail++;
                $display("FAIL wb_missing: no beat by cycle %0d, required data %h at cycle %0d", cyc, e.data, e.at);
            end
        end
    end

    initial begin : stimulus
        repeat (3) @(negedge clk_i);
        chk("rst_md_req", 32'(md_req_o), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_md_op", 32'(md_op_o), 32'd0);
        chk("rst_md_m_d_op", 32'(md_m_d_op_o), 32'd0);
        chk("rst_md_rs1", md_rs1_o, 32'd0);
        chk("rst_md_rs2", md_rs2_o, 32'd0);
        chk("rst_wb_rd", 32'(wb_rd_o), 32'd0);
        chk("rst_wb_data", wb_data_o, 32'd0);
        rst_ni = 1'b1;
        mon_en = 1'b1;
        @(negedge clk_i);

        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, 0, 0);
        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2, 0, 0);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0, 0);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd4, 0, 0);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 0, 0);
        issue(3'd7, 32'd7, 32'd2, 5'd6, 0, 0);
        issue(3'd5, 32'd5, 32'd0, 5'd7, 0, 0);
        issue(3'd6, 32'd5, 32'd0, 5'd8, 0, 0);
        issue(3'd2, 32'hFFFF_FFFF, 32'd3, 5'd9, 0, 0);
        issue(3'd0, 32'd123, 32'd0, 5'd10, 0, 0);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0, 0);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0, 0);
        // flush 10 cycles into BUSY, then a clean MUL at full latency
        issue(3'd0, 32'h55, 32'h66, 5'd13, 10, 0);
        issue(3'd0, 32'd3, 32'd4, 5'd14, 0, 0);
        // flush on the same cycle the unit reports ready
        issue(3'd7, 32'd100, 32'd7, 5'd15, 33, 0);
        // same operands, different result half: served from the cache when present
        issue(3'd1, 32'd3, 32'd4, 5'd16, 0, 0);
        issue(3'd0, 32'd3, 32'd4, 5'd17, 0, 0);

        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(), 5'($urandom_range(0, 31)), 0, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
        end

        // reset in the middle of a unit op, then recover
        issue(3'd3, 32'd1000, 32'd77, 5'd20, 5, 1);
        issue(3'd3, 32'd1000, 32'd77, 5'd21, 0, 0);
        issue(3'd5, 32'hFFFF_FFFF, 32'd0, 5'd22, 0, 0);

        repeat (40) @(negedge clk_i);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mul_div_ctrl.md
# mul_div_ctrl

- Execute-stage sequencer for RV32M instructions, sitting between the EX pipeline stage and the iterative `mul_div` unit.
- Accepts one M-extension operation, drives the unit's request handshake and operand ports, and stalls the pipeline while the unit iterates.
- Selects and sign-corrects the result (remainder sign, divide-by-zero remainder), then presents a one-cycle writeback beat.

## Interface
- No parameters; datapath fixed at 32 bits, rd at 5 bits.

- `clk_i` in 1: clock, all state on rising edge.
- `rst_ni` in 1: reset, synchronous, active-low.
- `ex_valid_i` in 1: EX presents an R-type M instruction.
- `ex_funct3_i` in 3: RV32M funct3 (000 MUL … 111 REMU).
- `ex_rs1_i`, `ex_rs2_i` in 32 each: operands.
- `ex_rd_i` in 5: destination register.
- `flush_i` in 1: kill the in-flight op.
- `stall_o` out 1: hold EX and upstream.
- `md_req_o` out 1: request to unit.
- `md_op_o` out 7: `INST_TYPE_R_M while `md_req_o`=1, else 0.
- `md_m_d_op_o` out 3: captured funct3.
- `md_rs1_o`, `md_rs2_o` out 32 each: captured operands.
- `md_rs1_signed_o`, `md_rs2_signed_o` out 1 each: operand signedness per funct3.
- `md_high_i`, `md_low_i` in 32 each: unit results.
- `md_ready_i` in 1: unit done.
- `wb_valid_o` out 1: writeback beat.
- `wb_rd_o` out 5: writeback register.
- `wb_data_o` out 32: writeback data.

## Operation
- States: IDLE, BUSY, WB.
- Accept occurs in IDLE or WB when `ex_valid_i`=1 and `flush_i`=0. On accept, register funct3, rs1, rs2 and rd.
  - Div/rem with rs2==0 (fast path) goes straight to WB and never raises `md_req_o`.
  - Otherwise go to BUSY.
- BUSY:
  - `md_req_o`=1, with captured operands held stable.
  - When `md_ready_i`=1: capture the result, drop `md_req_o` on that edge, go to WB.
- WB:
  - `wb_valid_o`=1 for exactly one cycle and `md_req_o`=0; this low cycle clears the unit's counter.
  - Next state is BUSY or WB on a new accept, else IDLE.
- Result selection:
  - MUL → low.
  - MULH/MULHSU/MULHU → high.
  - DIV/DIVU → low.
  - REM/REMU → high.
- Signedness:
  - rs1 signed for funct3 000/001/010/100/110.
  - rs2 signed for 000/001/100/110.
- Corrections:
  - REM (110) with rs1 negative → two's-complement negate the remainder.
  - Fast path: DIV/DIVU → 0xFFFFFFFF; REM/REMU → rs1.
  - Overflow −2^31 / −1 passes through the unit unchanged (quotient 0x80000000, rem 0).
- Flush:
  - `flush_i` in BUSY → `md_req_o`=0 next cycle, go to IDLE, no writeback.
  - `flush_i` has priority over accept and over a same-cycle `md_ready_i`.
  - `flush_i` in WB suppresses nothing; the beat is already committed.
- `stall_o` = (accept-eligible state & `ex_valid_i` & ~`flush_i`) | (state==BUSY).
  - Combinational.
  - Low in the WB cycle unless a new op is being accepted.

## Timing
- Reset values:
  - state IDLE.
  - `md_req_o`, `wb_valid_o`, `stall_o`=0.
  - `md_op_o`, `md_m_d_op_o`, operand outputs, `wb_rd_o`, `wb_data_o`=0.
- Latency, accept edge E0:
  - `md_req_o` is high from E0. The unit asserts ready after 32 request edges (E32), or after E1 for a zero operand.
  - The result is captured at the next edge.
  - `wb_valid_o` is high in the following cycle: 34 cycles for a normal op, 3 cycles for a zero operand.
- Fast path: `wb_valid_o` in the cycle after E0.
- Back-to-back: a new op accepted in WB starts BUSY on the next edge; at least one request-low cycle is guaranteed between ops.
- Reset mid-op: the next edge forces IDLE, `md_req_o`=0, no writeback.

## Configuration
- `MUL_DIV_CACHE_EN` defined:
  - Keep one entry holding {valid, m_d_op[2], rs1_signed, rs2_signed, rs1, rs2, high, low}, written on every unit completion.
  - An accept whose key matches the entry skips BUSY and writes back from the cache in the next cycle (e.g. MULH then MUL on the same operands).
  - The entry is invalidated by reset and by a flushed BUSY op.
- Undefined: no cache; every non-fast-path op uses the unit.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD → `wb_data_o`=0xFFFFFFEB, `wb_valid_o` 34 cycles after accept, `stall_o` high throughout BUSY.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- REM rs1=0xFFFFFFF9 (−7), rs2=2 → 0xFFFFFFFF; DIV same → 0xFFFFFFFD; REMU 7,2 → 1.
- DIVU rs1=5, rs2=0 → 0xFFFFFFFF and REM 5,0 → 5, each one cycle after accept with `md_req_o` never asserted.
- `flush_i` 10 cycles into BUSY → `md_req_o` low next cycle, no `wb_valid_o`; the following MUL 3×4 → 12 with full latency.
- With `MUL_DIV_CACHE_EN`: MULH 3,4 then MUL 3,4 → second result 12 one cycle after accept, `md_req_o` not raised.
